axi_lite_byte_regs: RTL and testbench

- Byte-addressable register file behind an AXI4-Lite slave port.
- Exposes every register byte in parallel to surrounding logic, which may also load bytes directly.
- Used as the configuration store of translation/peripheral blocks: software writes entries over AXI4-Lite, hardware consumes `reg_q_o`.

---
 rtl/axi_lite_byte_regs.sv | 206 ++++++++++++++++++++
 tb/tb_axi_lite_byte_regs.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_byte_regs.sv
// Byte-addressable register file behind an AXI4-Lite slave, every byte exposed in parallel.
// One outstanding read and one outstanding write; hardware loads beat AXI and stall colliding writes.
package axi_lite_byte_regs_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_chan_t;

  typedef struct packed {
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_lite_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } resp_lite_t;
endpackage

module axi_lite_byte_regs #(
  parameter int unsigned                   RegNumBytes  = 4,
  parameter int unsigned                   AxiAddrWidth = 32,
  parameter int unsigned                   AxiDataWidth = 32,
  parameter bit                            PrivProtOnly = 1'b0,
  parameter bit                            SecuProtOnly = 1'b0,
  parameter logic [RegNumBytes-1:0]        AxiReadOnly  = '0,
  parameter logic [RegNumBytes-1:0][7:0]   RegRstVal    = '0,
  parameter type                           req_lite_t   = axi_lite_byte_regs_pkg::req_lite_t,
  parameter type                           resp_lite_t  = axi_lite_byte_regs_pkg::resp_lite_t
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  req_lite_t                     axi_req_i,
  output resp_lite_t                    axi_resp_o,
  output logic [RegNumBytes-1:0]        wr_active_o,
  output logic [RegNumBytes-1:0]        rd_active_o,
  input  logic [RegNumBytes-1:0][7:0]   reg_d_i,
  input  logic [RegNumBytes-1:0]        reg_load_i,
  output logic [RegNumBytes-1:0][7:0]   reg_q_o
);
  localparam int unsigned StrbWidth = AxiDataWidth / 8;
  localparam int unsigned AddrLsb   = $clog2(StrbWidth);
  localparam int unsigned WordW     = AxiAddrWidth - AddrLsb;
  localparam int unsigned FullWords = RegNumBytes / StrbWidth;
  localparam int unsigned TailBytes = RegNumBytes % StrbWidth;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  typedef logic [RegNumBytes-1:0][7:0] bytes_t;

  bytes_t                  reg_q, reg_d;
  logic                    b_valid_q, b_valid_d;
  logic [1:0]              b_resp_q, b_resp_d;
  logic                    r_valid_q, r_valid_d;
  logic [1:0]              r_resp_q, r_resp_d;
  logic [AxiDataWidth-1:0] r_data_q, r_data_d;

  logic [WordW-1:0]        wr_word, rd_word;
  logic [StrbWidth-1:0]    wr_lane_ok, rd_lane_ok;
  logic [RegNumBytes-1:0]  wr_strobed, wr_writable, wr_apply, rd_byte_hit;
  bytes_t                  wr_bytes;
  logic [AxiDataWidth-1:0] rd_contrib [RegNumBytes];
  logic [AxiDataWidth-1:0] rd_data;
  logic                    wr_prot_ok, wr_err, wr_stall, wr_fire;
  logic                    rd_prot_ok, rd_err, rd_ready, rd_fire;

  assign wr_word = axi_req_i.aw.addr[AxiAddrWidth-1:AddrLsb];
  assign rd_word = axi_req_i.ar.addr[AxiAddrWidth-1:AddrLsb];

  // A lane is backed by a register byte only if base+lane < RegNumBytes.
  for (genvar i = 0; i < StrbWidth; i++) begin : g_lane
    localparam bit HasTail = (i < TailBytes);
    assign wr_lane_ok[i] = (wr_word < WordW'(FullWords)) ||
                           (HasTail && (wr_word == WordW'(FullWords)));
    assign rd_lane_ok[i] = (rd_word < WordW'(FullWords)) ||
                           (HasTail && (rd_word == WordW'(FullWords)));
  end

  for (genvar k = 0; k < RegNumBytes; k++) begin : g_byte
    localparam int unsigned Lane = k % StrbWidth;
    localparam int unsigned Word = k / StrbWidth;
    assign wr_strobed[k]  = (wr_word == WordW'(Word)) && axi_req_i.w.strb[Lane];
    assign wr_bytes[k]    = axi_req_i.w.data[8*Lane +: 8];
    assign rd_byte_hit[k] = (rd_word == WordW'(Word));
    assign rd_contrib[k]  = rd_byte_hit[k] ? (AxiDataWidth'(reg_q[k]) << (8*Lane)) : '0;
  end

  assign wr_prot_ok  = !(PrivProtOnly && !axi_req_i.aw.prot[0]) &&
                       !(SecuProtOnly && axi_req_i.aw.prot[1]);
  assign rd_prot_ok  = !(PrivProtOnly && !axi_req_i.ar.prot[0]) &&
                       !(SecuProtOnly && axi_req_i.ar.prot[1]);
  assign wr_writable = wr_strobed & ~AxiReadOnly;

  // An empty strobe is a legal no-op; otherwise at least one byte must be writable.
  assign wr_err   = !wr_prot_ok ||
                    (|(axi_req_i.w.strb & ~wr_lane_ok)) ||
                    ((|axi_req_i.w.strb) && !(|wr_writable));
  assign wr_apply = wr_err ? '0 : wr_writable;
  assign wr_stall = |(wr_apply & reg_load_i);
  assign wr_fire  = !rst_i && axi_req_i.aw_valid && axi_req_i.w_valid && !wr_stall &&
                    (!b_valid_q || axi_req_i.b_ready);

  assign rd_err   = !rd_prot_ok || !(|rd_lane_ok);
  assign rd_ready = !rst_i && (!r_valid_q || axi_req_i.r_ready);
  assign rd_fire  = rd_ready && axi_req_i.ar_valid;

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < RegNumBytes; k++) begin
      rd_data = rd_data | rd_contrib[k];
    end
  end

  always_comb begin
    reg_d = reg_q;
    for (int k = 0; k < RegNumBytes; k++) begin
      if (wr_fire && wr_apply[k]) reg_d[k] = wr_bytes[k];
      if (reg_load_i[k])          reg_d[k] = reg_d_i[k];
    end
  end

  always_comb begin
    b_valid_d = b_valid_q;
    b_resp_d  = b_resp_q;
    if (b_valid_q && axi_req_i.b_ready) b_valid_d = 1'b0;
    if (wr_fire) begin
      b_valid_d = 1'b1;
      b_resp_d  = wr_err ? RespSlvErr : RespOkay;
    end
  end

  always_comb begin
    r_valid_d = r_valid_q;
    r_resp_d  = r_resp_q;
    r_data_d  = r_data_q;
    if (r_valid_q && axi_req_i.r_ready) r_valid_d = 1'b0;
    if (rd_fire) begin
      r_valid_d = 1'b1;
      r_resp_d  = rd_err ? RespSlvErr : RespOkay;
      r_data_d  = rd_err ? '0 : rd_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_q     <= RegRstVal;
      b_valid_q <= 1'b0;
      b_resp_q  <= RespOkay;
      r_valid_q <= 1'b0;
      r_resp_q  <= RespOkay;
      r_data_q  <= '0;
    end else begin
      reg_q     <= reg_d;
      b_valid_q <= b_valid_d;
      b_resp_q  <= b_resp_d;
      r_valid_q <= r_valid_d;
      r_resp_q  <= r_resp_d;
      r_data_q  <= r_data_d;
    end
  end

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = wr_fire;
    axi_resp_o.w_ready  = wr_fire;
    axi_resp_o.b_valid  = b_valid_q;
    axi_resp_o.b.resp   = b_resp_q;
    axi_resp_o.ar_ready = rd_ready;
    axi_resp_o.r_valid  = r_valid_q;
    axi_resp_o.r.resp   = r_resp_q;
    axi_resp_o.r.data   = r_data_q;
  end

  assign wr_active_o = wr_fire ? wr_apply : '0;
  assign rd_active_o = (rd_fire && !rd_err) ? rd_byte_hit : '0;
  assign reg_q_o     = reg_q;

  logic unused_bits;
  assign unused_bits = ^{axi_req_i.aw.addr[AddrLsb-1:0], axi_req_i.ar.addr[AddrLsb-1:0],
                         axi_req_i.aw.prot[2], axi_req_i.ar.prot[2]};
endmodule

// File: tb/tb_axi_lite_byte_regs.sv
// Directed bench for axi_lite_byte_regs: three instances cover reset values, read-only bytes and
// privileged-only access; dut0 also exercises B back-pressure and hardware-load collisions.
module tb_axi_lite_byte_regs;
  import axi_lite_byte_regs_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  req_lite_t   req      [3];
  resp_lite_t  resp     [3];
  logic [3:0]  wr_act   [3];
  logic [3:0]  rd_act   [3];
  logic [31:0] reg_d    [3];
  logic [3:0]  reg_load [3];
  logic [31:0] reg_q    [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_lite_byte_regs #(
    .RegNumBytes(4), .RegRstVal(32'h1122_3344),
    .req_lite_t(req_lite_t), .resp_lite_t(resp_lite_t)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst), .axi_req_i(req[0]), .axi_resp_o(resp[0]),
    .wr_active_o(wr_act[0]), .rd_active_o(rd_act[0]),
    .reg_d_i(reg_d[0]), .reg_load_i(reg_load[0]), .reg_q_o(reg_q[0])
  );

  axi_lite_byte_regs #(
    .RegNumBytes(4), .AxiReadOnly(4'b0011),
    .req_lite_t(req_lite_t), .resp_lite_t(resp_lite_t)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst), .axi_req_i(req[1]), .axi_resp_o(resp[1]),
    .wr_active_o(wr_act[1]), .rd_active_o(rd_act[1]),
    .reg_d_i(reg_d[1]), .reg_load_i(reg_load[1]), .reg_q_o(reg_q[1])
  );

  axi_lite_byte_regs #(
    .RegNumBytes(4), .PrivProtOnly(1'b1),
    .req_lite_t(req_lite_t), .resp_lite_t(resp_lite_t)
  ) u_dut2 (
    .clk_i(clk), .rst_i(rst), .axi_req_i(req[2]), .axi_resp_o(resp[2]),
    .wr_active_o(wr_act[2]), .rd_active_o(rd_act[2]),
    .reg_d_i(reg_d[2]), .reg_load_i(reg_load[2]), .reg_q_o(reg_q[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input int d, input string tag, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot,
                           output logic [1:0] bresp, output logic [3:0] wact);
    int cnt;
    cnt = 0;
    @(posedge clk); #1;
    req[d].aw.addr  = addr;
    req[d].aw.prot  = prot;
    req[d].w.data   = data;
    req[d].w.strb   = strb;
    req[d].aw_valid = 1'b1;
    req[d].w_valid  = 1'b1;
    req[d].b_ready  = 1'b1;
    @(negedge clk);
    while (!resp[d].aw_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_aw_handshake"}, 32'(cnt < 50), 32'd1);
    chk({tag, "_b_not_early"}, 32'(resp[d].b_valid), 32'd0);
    wact = wr_act[d];
    @(posedge clk); #1;
    req[d].aw_valid = 1'b0;
    req[d].w_valid  = 1'b0;
    @(negedge clk);
    chk({tag, "_b_valid"}, 32'(resp[d].b_valid), 32'd1);
    bresp = resp[d].b.resp;
  endtask

  task automatic axi_read(input int d, input string tag, input logic [31:0] addr,
                          input logic [2:0] prot, output logic [31:0] rdata,
                          output logic [1:0] rresp, output logic [3:0] ract);
    int cnt;
    cnt = 0;
    @(posedge clk); #1;
    req[d].ar.addr  = addr;
    req[d].ar.prot  = prot;
    req[d].ar_valid = 1'b1;
    req[d].r_ready  = 1'b1;
    @(negedge clk);
    while (!resp[d].ar_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_ar_handshake"}, 32'(cnt < 50), 32'd1);
    ract = rd_act[d];
    @(posedge clk); #1;
    req[d].ar_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_r_valid"}, 32'(resp[d].r_valid), 32'd1);
    rdata = resp[d].r.data;
    rresp = resp[d].r.resp;
  endtask

  initial begin
    logic [1:0]  bresp, rresp;
    logic [3:0]  wact, ract;
    logic [31:0] rdata;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req[i]         = '0;
      req[i].b_ready = 1'b1;
      req[i].r_ready = 1'b1;
      reg_d[i]       = '0;
      reg_load[i]    = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_reg_q0", reg_q[0], 32'h1122_3344);
    chk("rst_reg_q1", reg_q[1], 32'h0000_0000);
    chk("rst_b_valid0", 32'(resp[0].b_valid), 32'd0);
    chk("rst_r_valid0", 32'(resp[0].r_valid), 32'd0);
    chk("rst_aw_ready0", 32'(resp[0].aw_ready), 32'd0);
    chk("rst_ar_ready0", 32'(resp[0].ar_ready), 32'd1);

    // Full-word write and read-back
    axi_write(0, "wr_full", 32'h0, 32'hDEAD_BEEF, 4'hF, 3'b000, bresp, wact);
    chk("wr_full_resp", 32'(bresp), 32'h0);
    chk("wr_full_active", 32'(wact), 32'hF);
    chk("wr_full_reg_q", reg_q[0], 32'hDEAD_BEEF);
    chk("wr_full_active_clear", 32'(wr_act[0]), 32'h0);
    axi_read(0, "rd_full", 32'h0, 3'b000, rdata, rresp, ract);
    chk("rd_full_data", rdata, 32'hDEAD_BEEF);
    chk("rd_full_resp", 32'(rresp), 32'h0);
    chk("rd_full_active", 32'(ract), 32'hF);

    // Read-only low bytes
    axi_write(1, "ro_partial", 32'h0, 32'hAABB_CCDD, 4'hF, 3'b000, bresp, wact);
    chk("ro_partial_resp", 32'(bresp), 32'h0);
    chk("ro_partial_active", 32'(wact), 32'hC);
    chk("ro_partial_reg_q", reg_q[1], 32'hAABB_0000);
    axi_write(1, "ro_only", 32'h0, 32'h1234_5678, 4'h3, 3'b000, bresp, wact);
    chk("ro_only_resp", 32'(bresp), 32'h2);
    chk("ro_only_active", 32'(wact), 32'h0);
    chk("ro_only_reg_q", reg_q[1], 32'hAABB_0000);
    axi_read(1, "ro_rd", 32'h0, 3'b000, rdata, rresp, ract);
    chk("ro_rd_data", rdata, 32'hAABB_0000);
    chk("ro_rd_resp", 32'(rresp), 32'h0);

    // Out-of-range word
    axi_write(0, "oor_wr", 32'h4, 32'h0102_0304, 4'hF, 3'b000, bresp, wact);
    chk("oor_wr_resp", 32'(bresp), 32'h2);
    chk("oor_wr_reg_q", reg_q[0], 32'hDEAD_BEEF);
    axi_read(0, "oor_rd", 32'h4, 3'b000, rdata, rresp, ract);
    chk("oor_rd_data", rdata, 32'h0);
    chk("oor_rd_resp", 32'(rresp), 32'h2);
    chk("oor_rd_active", 32'(ract), 32'h0);

    // Empty strobe is a harmless OKAY
    axi_write(0, "zero_strb", 32'h0, 32'hFFFF_FFFF, 4'h0, 3'b000, bresp, wact);
    chk("zero_strb_resp", 32'(bresp), 32'h0);
    chk("zero_strb_reg_q", reg_q[0], 32'hDEAD_BEEF);

    // Privileged-only instance
    axi_write(2, "unpriv", 32'h0, 32'h0102_0304, 4'hF, 3'b000, bresp, wact);
    chk("unpriv_resp", 32'(bresp), 32'h2);
    chk("unpriv_reg_q", reg_q[2], 32'h0);
    axi_write(2, "priv", 32'h0, 32'h0102_0304, 4'hF, 3'b001, bresp, wact);
    chk("priv_resp", 32'(bresp), 32'h0);
    chk("priv_reg_q", reg_q[2], 32'h0102_0304);

    // B back-pressure: a second write waits while b_ready is low
    @(posedge clk); #1;
    req[0].aw.addr  = 32'h0;
    req[0].aw.prot  = 3'b000;
    req[0].w.data   = 32'h0000_00AA;
    req[0].w.strb   = 4'h1;
    req[0].aw_valid = 1'b1;
    req[0].w_valid  = 1'b1;
    req[0].b_ready  = 1'b0;
    @(negedge clk);
    chk("bp_first_aw_ready", 32'(resp[0].aw_ready), 32'd1);
    @(posedge clk); #1;
    req[0].w.data = 32'h1111_1111;
    req[0].w.strb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_b_valid_held", 32'(resp[0].b_valid), 32'd1);
      chk("bp_aw_ready_low", 32'(resp[0].aw_ready), 32'd0);
      chk("bp_b_resp", 32'(resp[0].b.resp), 32'h0);
    end
    @(posedge clk); #1;
    req[0].aw_valid = 1'b0;
    req[0].w_valid  = 1'b0;
    req[0].b_ready  = 1'b1;
    @(negedge clk);
    chk("bp_b_valid_at_ready", 32'(resp[0].b_valid), 32'd1);
    @(negedge clk);
    chk("bp_b_valid_drop", 32'(resp[0].b_valid), 32'd0);
    chk("bp_reg_q", reg_q[0], 32'hDEAD_BEAA);

    // Hardware load on byte0 stalls an AXI write to byte0
    @(posedge clk); #1;
    reg_load[0]     = 4'h1;
    reg_d[0]        = 32'h0000_0055;
    req[0].aw.addr  = 32'h0;
    req[0].w.data   = 32'h0000_0077;
    req[0].w.strb   = 4'h1;
    req[0].aw_valid = 1'b1;
    req[0].w_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("col_aw_stalled", 32'(resp[0].aw_ready), 32'd0);
    end
    chk("col_load_wins", reg_q[0], 32'hDEAD_BE55);
    @(posedge clk); #1;
    reg_load[0] = 4'h0;
    @(negedge clk);
    chk("col_aw_released", 32'(resp[0].aw_ready), 32'd1);
    chk("col_wr_active", 32'(wr_act[0]), 32'h1);
    @(posedge clk); #1;
    req[0].aw_valid = 1'b0;
    req[0].w_valid  = 1'b0;
    @(negedge clk);
    chk("col_b_valid", 32'(resp[0].b_valid), 32'd1);
    chk("col_b_resp", 32'(resp[0].b.resp), 32'h0);
    chk("col_reg_q", reg_q[0], 32'hDEAD_BE77);

    // Plain hardware load of a single byte
    @(posedge clk); #1;
    reg_load[0] = 4'h8;
    reg_d[0]    = 32'h9900_0000;
    @(posedge clk); #1;
    reg_load[0] = 4'h0;
    @(negedge clk);
    chk("hw_load_reg_q", reg_q[0], 32'h99AD_BE77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
